// File: rtl/test_host_if.sv
// Test host interface: TOHOST pass/fail mailbox, console byte FIFO, STATUS and CYCLES registers.
// Optional feature: define TEST_HOST_WATCHDOG_EN to enable the RUN -> TMO watchdog after TIMEOUT cycles.
module test_host_if #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] TIMEOUT    = 32'd100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        con_valid,
  input  logic        con_ready,
  output logic [7:0]  con_data,
  output logic        test_done,
  output logic        test_pass,
  output logic [30:0] fail_code
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

`ifdef TEST_HOST_WATCHDOG_EN
  localparam bit WATCHDOG_EN = 1'b1;
`else
  localparam bit WATCHDOG_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2,
    ST_TMO  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    REG_TOHOST  = 2'd0,
    REG_CONSOLE = 2'd1,
    REG_STATUS  = 2'd2,
    REG_CYCLES  = 2'd3
  } reg_sel_t;

  state_t            state_q, state_d;
  logic [30:0]       fail_code_q, fail_code_d;
  logic [31:0]       cycles_q;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;

  reg_sel_t          sel;
  logic              fifo_full, fifo_empty;
  logic              req_fire, push, pop;
  logic              tohost_end;
  logic              terminal;
  logic [31:0]       status_word;
  logic [31:0]       read_data;
  logic              unused_addr_bits;

  assign sel              = reg_sel_t'(req_addr[3:2]);
  assign unused_addr_bits = ^req_addr[1:0];

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // A console write into a full FIFO stalls even if a pop happens on the same edge.
  assign req_ready = rst || !(req_valid && req_we && (sel == REG_CONSOLE) && fifo_full);
  assign req_fire  = req_valid && req_ready && !rst;
  assign push      = req_fire && req_we && (sel == REG_CONSOLE);
  assign pop       = !fifo_empty && con_ready && !rst;

  assign tohost_end = req_fire && req_we && (sel == REG_TOHOST) && req_wdata[0];
  assign terminal   = (state_q != ST_RUN);

  assign con_valid = !fifo_empty && !rst;
  assign con_data  = con_valid ? mem[rd_ptr_q] : 8'h00;
  assign test_done = terminal && !rst;
  assign test_pass = (state_q == ST_PASS) && !rst;
  assign fail_code = fail_code_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rst ? 32'h0 : rsp_rdata_q;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    fail_code_d = fail_code_q;
    if (state_q == ST_RUN) begin
      if (tohost_end) begin
        if (req_wdata == 32'h1) begin
          state_d = ST_PASS;
        end else begin
          state_d     = ST_FAIL;
          fail_code_d = req_wdata[31:1];
        end
      end else if (WATCHDOG_EN && (cycles_q == TIMEOUT - 32'd1)) begin
        state_d = ST_TMO;
      end
    end
  end

  always_comb begin
    status_word       = '0;
    status_word[0]    = terminal;
    status_word[1]    = (state_q == ST_PASS);
    status_word[2]    = (state_q == ST_TMO);
    status_word[3]    = fifo_full;
    status_word[15:8] = 8'(count_q);
  end

  // TOHOST and CONSOLE are write-only; reading them returns 0, as do all writes.
  always_comb begin
    read_data = '0;
    if (!req_we) begin
      case (sel)
        REG_STATUS: read_data = status_word;
        REG_CYCLES: read_data = cycles_q;
        default:    read_data = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      fail_code_q <= '0;
      cycles_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      fail_code_q <= fail_code_d;
      // Counter freezes on the edge that enters a terminal state.
      if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
        cycles_q <= cycles_q + 32'd1;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      rsp_valid_q <= req_fire;
      rsp_rdata_q <= req_fire ? read_data : 32'h0;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= req_wdata[7:0];
    end
  end

endmodule

// File: tb/tb_test_host_if.sv
// Self-checking bench for test_host_if: response scoreboard, console byte queue and a second
// instance with TIMEOUT=16 for the watchdog behaviour (expectations follow TEST_HOST_WATCHDOG_EN).
module tb_test_host_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        con_valid, con_ready;
  logic [7:0]  con_data;
  logic        test_done, test_pass;
  logic [30:0] fail_code;

  logic        wd_req_valid, wd_req_ready, wd_req_we;
  logic [3:0]  wd_req_addr;
  logic [31:0] wd_req_wdata;
  logic        wd_rsp_valid;
  logic [31:0] wd_rsp_rdata;
  logic        wd_con_valid;
  logic        wd_con_ready;
  logic [7:0]  wd_con_data;
  logic        wd_test_done, wd_test_pass;
  logic [30:0] wd_fail_code;

  localparam logic [3:0] A_TOHOST  = 4'h0;
  localparam logic [3:0] A_CONSOLE = 4'h4;
  localparam logic [3:0] A_STATUS  = 4'h8;
  localparam logic [3:0] A_CYCLES  = 4'hC;

`ifdef TEST_HOST_WATCHDOG_EN
  localparam logic [31:0] WD_STATUS_EXP = 32'h5;
  localparam logic [31:0] WD_CYCLES_EXP = 32'd15;
  localparam logic [31:0] WD_DONE_EXP   = 32'd1;
`else
  localparam logic [31:0] WD_STATUS_EXP = 32'h0;
  localparam logic [31:0] WD_CYCLES_EXP = 32'd21;
  localparam logic [31:0] WD_DONE_EXP   = 32'd0;
`endif

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  rsp_t       sb_q[$];
  logic [7:0] con_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         rel_cyc  = 0;

  test_host_if dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .con_valid(con_valid), .con_ready(con_ready), .con_data(con_data),
    .test_done(test_done), .test_pass(test_pass), .fail_code(fail_code)
  );

  test_host_if #(.FIFO_DEPTH(8), .TIMEOUT(32'd16)) dut_wd (
    .clk(clk), .rst(rst),
    .req_valid(wd_req_valid), .req_ready(wd_req_ready), .req_we(wd_req_we),
    .req_addr(wd_req_addr), .req_wdata(wd_req_wdata),
    .rsp_valid(wd_rsp_valid), .rsp_rdata(wd_rsp_rdata),
    .con_valid(wd_con_valid), .con_ready(wd_con_ready), .con_data(wd_con_data),
    .test_done(wd_test_done), .test_pass(wd_test_pass), .fail_code(wd_fail_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Response and console monitors, sampled on the falling edge.
  always @(negedge clk) begin
    rsp_t e;
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_rdata", rsp_rdata, e.data);
    end else begin
      check("rsp_idle", 32'(rsp_valid), 32'd0);
    end
    if (!rst && con_valid && con_ready) begin
      if (con_q.size() == 0) check("con_extra_pop", 32'(con_q.size()), 32'd1);
      else check("con_data", 32'(con_data), 32'(con_q.pop_front()));
    end
  end

  // Caller is just after a rising edge; returns just after the acceptance edge.
  task automatic do_req(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp, output int acc);
    rsp_t e;
    int budget = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    @(negedge clk);
    while (!req_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    acc = cyc;
    if (!req_ready) begin
      check("req_ready_timeout", 32'(req_ready), 32'd1);
    end else begin
      e.data = exp;
      e.due  = cyc + 1;
      sb_q.push_back(e);
      if (we && addr[3:2] == 2'd1) con_q.push_back(wd[7:0]);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] wd);
    int acc;
    do_req(1'b1, addr, wd, 32'h0, acc);
  endtask

  task automatic rd(input logic [3:0] addr, input logic [31:0] exp);
    int acc;
    do_req(1'b0, addr, 32'h0, exp, acc);
  endtask

  task automatic wait_drain();
    int budget = 0;
    @(negedge clk);
    while ((con_q.size() != 0 || con_valid) && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("drain_con_valid", 32'(con_valid), 32'd0);
    check("drain_queue", 32'(con_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int acc_pass;
    logic [31:0] frozen;

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    con_ready = 1'b1;
    wd_req_valid = 1'b0; wd_req_we = 1'b0; wd_req_addr = '0; wd_req_wdata = '0;
    wd_con_ready = 1'b1;

    // Outputs while reset is held.
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_con_valid", 32'(con_valid), 32'd0);
    check("rst_con_data", 32'(con_data), 32'd0);
    check("rst_test_done", 32'(test_done), 32'd0);
    check("rst_test_pass", 32'(test_pass), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_fail_code", 32'(fail_code), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rel_cyc = cyc;

    // Watchdog instance: idle 20 cycles, then STATUS and CYCLES back-to-back.
    repeat (20) @(posedge clk);
    #1;
    wd_req_valid = 1'b1;
    wd_req_addr  = A_STATUS;
    @(posedge clk);
    #1;
    check("wd_status_valid", 32'(wd_rsp_valid), 32'd1);
    check("wd_status", wd_rsp_rdata, WD_STATUS_EXP);
    wd_req_addr = A_CYCLES;
    @(posedge clk);
    #1;
    wd_req_valid = 1'b0;
    check("wd_cycles_valid", 32'(wd_rsp_valid), 32'd1);
    check("wd_cycles", wd_rsp_rdata, WD_CYCLES_EXP);
    check("wd_test_done", 32'(wd_test_done), WD_DONE_EXP);
    check("wd_test_pass", 32'(wd_test_pass), 32'd0);

    // Idle register reads; writes to STATUS/CYCLES are ignored but respond.
    rd(A_STATUS, 32'h0);
    wr(A_STATUS, 32'hFFFF_FFFF);
    wr(A_CYCLES, 32'h1234_5678);
    rd(A_STATUS, 32'h0);

    // Fill the FIFO with the sink stalled, then stall a ninth write.
    con_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(A_CONSOLE, 32'hA0 + i);
    rd(A_STATUS, 32'h0000_0808);
    repeat (2) begin
      @(negedge clk);
      check("con_hold_valid", 32'(con_valid), 32'd1);
      check("con_hold_data", 32'(con_data), 32'hA0);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = A_CONSOLE; req_wdata = 32'hA8;
    repeat (2) begin
      @(negedge clk);
      check("full_stall", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    con_ready = 1'b1;
    wr(A_CONSOLE, 32'hA8);
    wait_drain();

    // Three queued bytes, then push and pop every cycle across the pointer wrap.
    con_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr(A_CONSOLE, 32'hB0 + i);
    con_ready = 1'b1;
    for (int i = 3; i < 10; i++) wr(A_CONSOLE, 32'hB0 + i);
    rd(A_STATUS, 32'h0000_0300);
    wait_drain();

    // TOHOST with bit 0 clear does nothing; 1 passes; later writes are ignored.
    wr(A_TOHOST, 32'h2);
    check("nonterminal_done", 32'(test_done), 32'd0);
    do_req(1'b1, A_TOHOST, 32'h1, 32'h0, acc_pass);
    frozen = 32'(acc_pass - rel_cyc);
    check("pass_done", 32'(test_done), 32'd1);
    check("pass_pass", 32'(test_pass), 32'd1);
    rd(A_STATUS, 32'h3);
    wr(A_TOHOST, 32'h5);
    check("pass_sticky", 32'(test_pass), 32'd1);
    check("pass_fail_code", 32'(fail_code), 32'd0);
    rd(A_CYCLES, frozen);

    // Console keeps draining in a terminal state.
    wr(A_CONSOLE, 32'hD5);
    wait_drain();

    // Reset in PASS with two bytes queued and a request pending.
    con_ready = 1'b0;
    wr(A_CONSOLE, 32'hC0);
    wr(A_CONSOLE, 32'hC1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = A_STATUS;
    @(negedge clk);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_con_valid", 32'(con_valid), 32'd0);
    check("mid_rst_test_done", 32'(test_done), 32'd0);
    con_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 1'b0;
    rel_cyc = cyc;
    check("post_rst_con_valid", 32'(con_valid), 32'd0);
    check("post_rst_con_data", 32'(con_data), 32'd0);
    check("post_rst_test_done", 32'(test_done), 32'd0);
    check("post_rst_test_pass", 32'(test_pass), 32'd0);
    con_ready = 1'b1;
    rd(A_CYCLES, 32'h0);
    rd(A_STATUS, 32'h0);

    // Failing TOHOST value; first result wins.
    wr(A_TOHOST, 32'h7);
    check("fail_done", 32'(test_done), 32'd1);
    check("fail_pass", 32'(test_pass), 32'd0);
    check("fail_code", 32'(fail_code), 32'd3);
    wr(A_TOHOST, 32'h1);
    check("fail_sticky_pass", 32'(test_pass), 32'd0);
    check("fail_sticky_code", 32'(fail_code), 32'd3);
    rd(A_STATUS, 32'h1);

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/test_host_if.md
TEST_HOST_IF -- requirements
Module: test_host_if

Interface
- REQ-001 Parameter FIFO_DEPTH, default 8, console FIFO entries (power of two, 2..64).
- REQ-002 Parameter TIMEOUT, default 32'd100000, watchdog limit in cycles.
- REQ-003 clk  in  1  single clock; all logic on its rising edge.
- REQ-004 rst  in  1  synchronous, active-high reset.
- REQ-005 req_valid  in  1  core store/load request valid.
- REQ-006 req_ready  out  1  request accepted when req_valid && req_ready.
- REQ-007 req_we  in  1  1 = write, 0 = read.
- REQ-008 req_addr  in  4  byte offset; [3:2] selects: 0 TOHOST, 1 CONSOLE, 2 STATUS, 3 CYCLES.
- REQ-009 req_wdata  in  32  write data.
- REQ-010 rsp_valid  out  1  one-cycle response pulse.
- REQ-011 rsp_rdata  out  32  read data; 0 for writes.
- REQ-012 con_valid  out  1  console byte available.
- REQ-013 con_ready  in  1  console sink takes byte when con_valid && con_ready.
- REQ-014 con_data  out  8  console byte (FIFO head).
- REQ-015 test_done  out  1  terminal state reached.
- REQ-016 test_pass  out  1  valid when test_done.
- REQ-017 fail_code  out  31  TOHOST[31:1] of failing write.

Function
- REQ-018 FSM states RUN, PASS, FAIL, TMO; test_done=1 in PASS/FAIL/TMO; test_pass=1 only in PASS.
- REQ-019 RUN + accepted TOHOST write with wdata[0]=1: wdata==1 -> PASS; else -> FAIL, fail_code=wdata[31:1]; taken at the next edge.
- REQ-020 TOHOST write with wdata[0]=0 in RUN: no state change.
- REQ-021 Terminal states hold until rst; later TOHOST writes leave state and fail_code unchanged (first result wins).
- REQ-022 CONSOLE write pushes wdata[7:0]; req_ready=0 for a CONSOLE write while FIFO full (no bypass of same-cycle pop); all other requests have req_ready=1.
- REQ-023 Pop on con_valid && con_ready; con_valid = FIFO not empty; con_data stable while con_valid && !con_ready.
- REQ-024 Simultaneous push and pop with FIFO non-empty, non-full: count unchanged, order preserved; pointers wrap modulo FIFO_DEPTH.
- REQ-025 Every accepted request gives rsp_valid=1 exactly one cycle later; back-to-back requests give back-to-back responses.
- REQ-026 STATUS read: [0] done, [1] pass, [2] timeout, [3] fifo full, [15:8] fifo count, other bits 0; value sampled at acceptance cycle.
- REQ-027 CYCLES read: 32-bit free-running cycle counter, counts from 0 after reset, wraps at 2^32, freezes on entering any terminal state.
- REQ-028 Writes to STATUS and CYCLES are ignored but still respond.
- REQ-029 Console FIFO keeps draining in terminal states.

Reset
- REQ-030 rst=1 at an edge: state RUN, FIFO empty, pointers 0, cycle counter 0, fail_code 0, rsp_valid 0, pending response dropped.
- REQ-031 Outputs during/after reset: req_ready 1, con_valid 0, con_data 0, test_done 0, test_pass 0, rsp_rdata 0.
- REQ-032 rst mid-request: request in that cycle not accepted and gets no response.

Configuration
- REQ-033 Macro TEST_HOST_WATCHDOG_EN defined: RUN -> TMO when cycle counter reaches TIMEOUT-1 without a terminal TOHOST write; STATUS[2]=1 in TMO; TOHOST write on the same edge has priority.
- REQ-034 TEST_HOST_WATCHDOG_EN undefined: no TMO state reachable, STATUS[2] reads 0, counter still runs.

Verification
- REQ-035 Reset, write TOHOST=32'h1 -> next cycle test_done=1, test_pass=1; STATUS read = 32'h3.
- REQ-036 Write TOHOST=32'h7, then TOHOST=32'h1 -> FAIL, fail_code=3, unchanged by second write.
- REQ-037 con_ready=0, write CONSOLE 9 times (DEPTH 8) -> 9th stalls (req_ready=0) and STATUS[15:8]=8; con_ready=1 -> bytes drained in order, 9th accepted.
- REQ-038 Simultaneous CONSOLE push and pop with count 3 -> count stays 3, order preserved across pointer wrap.
- REQ-039 With TEST_HOST_WATCHDOG_EN, TIMEOUT=16, no TOHOST -> TMO at cycle 15, STATUS=32'h5, CYCLES reads 15; without macro -> state stays RUN.
- REQ-040 Assert rst in PASS with FIFO holding 2 bytes -> RUN, con_valid=0, CYCLES reads 0 afterwards.
